x74123_mono_array: RTL

- Parametrised, clocked successor to the single-shot 74121 model: CH independent monostable channels.
- Each channel uses 74-series trigger logic: A active-low, B active-high, plus an active-low clear.
- Pulse width is measured in clock cycles and set per channel; each channel is retriggerable or non-retriggerable.
- Sits in the discrete-logic model library as the synthesizable one-shot used by timing and debounce glue.

---
 rtl/x74_pkg.sv | 37 +++
 rtl/x74_mono_ch.sv | 140 ++++++++++++++
 rtl/x74123_mono_array.sv | 71 +++++++
 3 files changed

// File: rtl/x74_pkg.sv
// -----------------------------------------------------------------------------
// x74_pkg
// Shared definitions for the clocked 74121/74123-style one-shot array.
//   MODE_NONRETRIG / MODE_RETRIG : per-channel mode encodings
//   DEF_CNT_W                    : default pulse-width counter width
//   width_slice()                : pulls one channel's width out of the packed
//                                  per-channel width bus
// -----------------------------------------------------------------------------
package x74_pkg;

  // Channel mode: non-retriggerable behaves like a 74121, retriggerable like
  // a 74123 (a new trigger restarts the timing interval).
  localparam logic MODE_NONRETRIG = 1'b0;
  localparam logic MODE_RETRIG    = 1'b1;

  // Default counter width; the longest pulse is 2^DEF_CNT_W-1 cycles.
  localparam int DEF_CNT_W = 16;

  // Bounds for the width-extraction helper. The top zero-extends its width
  // bus to WIDTH_BUS_W bits, so CH*CNT_W must not exceed this and CNT_W must
  // not exceed MAX_CNT_W.
  localparam int MAX_CNT_W   = 32;
  localparam int MAX_CH      = 64;
  localparam int WIDTH_BUS_W = MAX_CH * MAX_CNT_W;

  // Channel ch occupies bits [ch*cnt_w +: cnt_w] of the width bus. Shifting
  // the slice down to bit 0 keeps the select index a plain constant; the
  // caller truncates the result to its own counter width.
  function automatic logic [MAX_CNT_W-1:0] width_slice(
    input logic [WIDTH_BUS_W-1:0] bus,
    input int                     ch,
    input int                     cnt_w
  );
    return MAX_CNT_W'(bus >> (ch * cnt_w));
  endfunction

endpackage

// File: rtl/x74_mono_ch.sv
// -----------------------------------------------------------------------------
// x74_mono_ch
// One monostable channel: input synchroniser, 74-series trigger edge detect,
// pulse-width down-counter and registered q / q_n / done.
//
// Ports
//   clk    in  1      clock, rising edge
//   rst    in  1      synchronous active-high reset
//   a_n    in  1      trigger input A, active low
//   b      in  1      trigger input B, active high
//   clr_n  in  1      clear, active low (also gates the trigger term)
//   width  in  CNT_W  pulse width in cycles, sampled on the firing edge
//   q      out 1      pulse output, registered
//   q_n    out 1      complement of q, registered
//   done   out 1      one-cycle strobe when a pulse ends naturally
// -----------------------------------------------------------------------------
module x74_mono_ch
  import x74_pkg::*;
#(
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic RETRIG      = MODE_RETRIG,
  parameter int   SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_n,
  input  logic             b,
  input  logic             clr_n,
  input  logic [CNT_W-1:0] width,
  output logic             q,
  output logic             q_n,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic a_n_s;
  logic b_s;
  logic clr_n_s;
  logic sync_ok_s;   // high once the synchroniser holds post-reset samples

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      // Each stage carries {valid, a_n, b, clr_n}. The valid bit is a 1
      // shifted in behind the reset zeros, so it reaches the last stage in
      // step with the first real input sample.
      logic [3:0] sync_r [SYNC_STAGES];

      // Synchroniser shift chain for the three trigger inputs plus valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_r[k] <= 4'b0000;
          end
        end else begin
          sync_r[0] <= {1'b1, a_n, b, clr_n};
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_r[k] <= sync_r[k-1];
          end
        end
      end

      assign {sync_ok_s, a_n_s, b_s, clr_n_s} = sync_r[SYNC_STAGES-1];
    end else begin : g_nosync
      assign a_n_s     = a_n;
      assign b_s       = b;
      assign clr_n_s   = clr_n;
      assign sync_ok_s = 1'b1;
    end
  endgenerate

  logic             t_s;      // 74-series trigger term
  logic             fire_s;   // rising edge of the trigger term
  logic             load_s;   // fire accepted: (re)start the pulse
  logic             t_d_r;    // previous-cycle trigger term
  logic [CNT_W-1:0] cnt_r;    // cycles of q remaining, including this one
  logic             q_r;
  logic             q_n_r;
  logic             done_r;

  assign t_s    = ~a_n_s & b_s & clr_n_s;
  assign fire_s = t_s & ~t_d_r;
  // A zero width never starts a pulse; a non-retriggerable channel ignores
  // triggers while its pulse is running.
  assign load_s = fire_s & (width != CNT_ZERO) & (~q_r | RETRIG);

  // Edge history, pulse counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // t_d starts at 1 so an input already active through reset is not
      // mistaken for a fresh edge.
      t_d_r  <= 1'b1;
      cnt_r  <= CNT_ZERO;
      q_r    <= 1'b0;
      q_n_r  <= 1'b1;
      done_r <= 1'b0;
    end else begin
      // Until the synchroniser has flushed its reset zeros, keep the history
      // at 1 so the first real sample cannot look like a rising edge.
      t_d_r <= sync_ok_s ? t_s : 1'b1;

      if (!clr_n_s) begin
        // Clear wins over both a new trigger and the countdown; no done.
        cnt_r  <= CNT_ZERO;
        q_r    <= 1'b0;
        q_n_r  <= 1'b1;
        done_r <= 1'b0;
      end else if (load_s) begin
        // Also covers a retrigger landing on the final cycle: the reload
        // keeps q high and suppresses done.
        cnt_r  <= width;
        q_r    <= 1'b1;
        q_n_r  <= 1'b0;
        done_r <= 1'b0;
      end else if (cnt_r > CNT_ONE) begin
        cnt_r  <= cnt_r - CNT_ONE;
        q_r    <= 1'b1;
        q_n_r  <= 1'b0;
        done_r <= 1'b0;
      end else if (cnt_r == CNT_ONE) begin
        // Natural end of pulse.
        cnt_r  <= CNT_ZERO;
        q_r    <= 1'b0;
        q_n_r  <= 1'b1;
        done_r <= 1'b1;
      end else begin
        cnt_r  <= CNT_ZERO;
        q_r    <= 1'b0;
        q_n_r  <= 1'b1;
        done_r <= 1'b0;
      end
    end
  end

  assign q    = q_r;
  assign q_n  = q_n_r;
  assign done = done_r;

endmodule

// File: rtl/x74123_mono_array.sv
// -----------------------------------------------------------------------------
// x74123_mono_array
// CH independent clocked monostables with 74-series trigger logic
// (A active low, B active high, active-low clear). Pulse width is given in
// clock cycles per channel; each channel is retriggerable (74123 style) or
// non-retriggerable (74121 style) according to its RETRIG bit.
//
// Parameters
//   CH           number of channels
//   CNT_W        counter width per channel (max pulse 2^CNT_W-1 cycles)
//   RETRIG       per-channel mode, 1 = retriggerable, 0 = non-retriggerable
//   SYNC_STAGES  synchroniser depth on a_n/b/clr_n, 0 = already synchronous
//
// Ports
//   clk    in  1         clock, rising edge
//   rst    in  1         synchronous active-high reset
//   a_n    in  CH        trigger A per channel, active low
//   b      in  CH        trigger B per channel, active high
//   clr_n  in  CH        clear per channel, active low
//   width  in  CH*CNT_W  pulse widths, channel i at [i*CNT_W +: CNT_W]
//   q      out CH        pulse outputs, registered
//   q_n    out CH        complements of q
//   done   out CH        one-cycle strobe at natural pulse end
// -----------------------------------------------------------------------------
module x74123_mono_array
  import x74_pkg::*;
#(
  parameter int          CH          = 2,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter logic [CH-1:0] RETRIG    = {CH{1'b1}},
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       a_n,
  input  logic [CH-1:0]       b,
  input  logic [CH-1:0]       clr_n,
  input  logic [CH*CNT_W-1:0] width,
  output logic [CH-1:0]       q,
  output logic [CH-1:0]       q_n,
  output logic [CH-1:0]       done
);

  // Width bus widened to the helper's fixed size; upper bits are zero.
  logic [WIDTH_BUS_W-1:0] width_ext_s;
  assign width_ext_s = WIDTH_BUS_W'(width);

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [CNT_W-1:0] ch_width_s;
      assign ch_width_s = CNT_W'(width_slice(width_ext_s, i, CNT_W));

      x74_mono_ch #(
        .CNT_W       (CNT_W),
        .RETRIG      (RETRIG[i]),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .a_n   (a_n[i]),
        .b     (b[i]),
        .clr_n (clr_n[i]),
        .width (ch_width_s),
        .q     (q[i]),
        .q_n   (q_n[i]),
        .done  (done[i])
      );
    end
  endgenerate

endmodule
